// File: rtl/uart_arb_pkg.sv
// rtl/uart_arb_pkg.sv - shared states, limits and frame type for the UART message arbiter
package uart_arb_pkg;

    localparam int START_TO    = 8;
    localparam int DEF_CHAR_NR = 8;

    typedef logic [DEF_CHAR_NR*8-1:0] frame_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT_BUSY,
        ST_WAIT_DONE,
        ST_DONE,
        ST_CLR
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting after last_ptr
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] last_ptr,
    output logic [N-1:0]     gnt,
    output logic [PTR_W-1:0] idx,
    output logic             valid
);

    int   cand;
    logic found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_ptr) + k) % N;
            if (!found && req[PTR_W'(cand)]) begin
                found                = 1'b1;
                gnt[PTR_W'(cand)]    = 1'b1;
                idx                  = PTR_W'(cand);
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/uart_msg_arbiter.sv
// rtl/uart_msg_arbiter.sv - shares one uart_top transmitter between several frame sources
module uart_msg_arbiter
    import uart_arb_pkg::*;
#(
    parameter int CHAR_NR    = 8,
    parameter int NUM_REQ    = 3,
    parameter int TX_TIMEOUT = 2_000_000
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_REQ-1:0]                req_i,
    input  logic [NUM_REQ-1:0][CHAR_NR*8-1:0] frame_i,
    input  logic                              abort_i,
    output logic [NUM_REQ-1:0]                gnt_o,
    output logic [NUM_REQ-1:0]                done_o,
    output logic [NUM_REQ-1:0]                err_o,
    output logic [CHAR_NR*8-1:0]              uart_char_array_o,
    output logic                              uart_update_o,
    output logic                              uart_clr_o,
    input  logic                              uart_busy_i,
    output logic                              idle_o
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TX_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] START_LIM = CNT_W'(START_TO);
    localparam logic [CNT_W-1:0] TX_LIM    = CNT_W'(TX_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    arb_state_t             state_q, state_d;
    logic [PTR_W-1:0]       owner_q, owner_d;
    logic [NUM_REQ-1:0]     owner_oh_q, owner_oh_d;
    logic [PTR_W-1:0]       last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [CHAR_NR*8-1:0]   char_q, char_d;
    logic [NUM_REQ-1:0]     gnt_q, gnt_d, done_q, done_d, err_q, err_d;
    logic                   upd_q, upd_d, clr_q, clr_d, idle_q, idle_d;

    logic [NUM_REQ-1:0]     arb_gnt;
    logic [PTR_W-1:0]       arb_idx;
    logic                   arb_valid;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req      (req_i),
        .last_ptr (last_ptr_q),
        .gnt      (arb_gnt),
        .idx      (arb_idx),
        .valid    (arb_valid)
    );

    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_oh_d = owner_oh_q;
        last_ptr_d = last_ptr_q;
        char_d     = char_q;
        cnt_d      = cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    owner_d    = arb_idx;
                    owner_oh_d = arb_gnt;
                    char_d     = frame_i[arb_idx];
                    state_d    = ST_LOAD;
                end
            end
            ST_LOAD:  state_d = abort_i ? ST_CLR : ST_START;
            ST_START: begin
                cnt_d   = '0;
                state_d = abort_i ? ST_CLR : ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                cnt_d = cnt_inc;
                if (abort_i) begin
                    state_d = ST_CLR;
                end else if (uart_busy_i) begin
                    state_d = ST_WAIT_DONE;
                    cnt_d   = '0;
                end else if (cnt_inc >= START_LIM) begin
                    state_d = ST_CLR;
                end
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                // a falling busy beats a same-cycle abort or timeout
                if (!uart_busy_i) begin
                    state_d = ST_DONE;
                end else if (abort_i || cnt_inc >= TX_LIM) begin
                    state_d = ST_CLR;
                end
            end
            ST_DONE, ST_CLR: begin
                last_ptr_d = owner_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // outputs are registered from the state being entered
        gnt_d  = (state_d == ST_IDLE) ? '0 : owner_oh_d;
        done_d = (state_d == ST_DONE) ? owner_oh_d : '0;
        err_d  = (state_d == ST_CLR)  ? owner_oh_d : '0;
        upd_d  = (state_d == ST_START);
        clr_d  = (state_d == ST_CLR);
        idle_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            owner_oh_q <= '0;
            last_ptr_q <= PTR_W'(NUM_REQ - 1);
            cnt_q      <= '0;
            char_q     <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            err_q      <= '0;
            upd_q      <= 1'b0;
            clr_q      <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            owner_oh_q <= owner_oh_d;
            last_ptr_q <= last_ptr_d;
            cnt_q      <= cnt_d;
            char_q     <= char_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            err_q      <= err_d;
            upd_q      <= upd_d;
            clr_q      <= clr_d;
            idle_q     <= idle_d;
        end
    end

    assign gnt_o             = gnt_q;
    assign done_o            = done_q;
    assign err_o             = err_q;
    assign uart_char_array_o = char_q;
    assign uart_update_o     = upd_q;
    assign uart_clr_o        = clr_q;
    assign idle_o            = idle_q;

endmodule
